// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg.
// The producer, the consumer and the flush source sit on the master side.
// The stage itself sits on the slave side.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occupancy;

  // Testbench or surrounding pipeline: drives the offers, the consumer ready
  // and the flush.
  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  // The pipeline stage register.
  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid.
// The state encoding is the pair (skid_valid, main_valid), so the handshake
// outputs come straight from state flops. in_ready never depends
// combinationally on out_ready, which cuts the backpressure timing path.
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  pipe_skid_reg_if.slave   bus
);

  // Bit 0 is main_valid and bit 1 is skid_valid. 2'b10 (skid without main) is
  // illegal.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_LOAD_IN,
    MAIN_LOAD_SKID
  } main_sel_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;

  logic             w_main_valid;
  logic             w_skid_valid;
  logic             w_accept;
  logic             w_drain;
  main_sel_t        w_main_sel;
  logic             w_skid_load;

  assign w_main_valid = r_state[0];
  assign w_skid_valid = r_state[1];

  // Handshake events as seen at the coming rising edge.
  assign w_accept = bus.in_valid & ~w_skid_valid;
  assign w_drain  = w_main_valid & bus.out_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode. A flush overrides every accept or drain at that edge.
  // NOTE: w_state_nxt gets a default before the case statement, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) w_state_nxt = ST_ONE;
        end
        ST_ONE: begin
          if (w_accept && !w_drain)      w_state_nxt = ST_FULL;
          else if (!w_accept && w_drain) w_state_nxt = ST_EMPTY;
        end
        ST_FULL: begin
          if (w_drain) w_state_nxt = ST_ONE;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Datapath steering: decides which data register loads and from where.
  always_comb begin
    w_main_sel  = MAIN_HOLD;
    w_skid_load = 1'b0;
    if (!bus.flush) begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) w_main_sel = MAIN_LOAD_IN;
        end
        ST_ONE: begin
          if (w_accept && w_drain) w_main_sel  = MAIN_LOAD_IN;
          else if (w_accept)       w_skid_load = 1'b1;
        end
        ST_FULL: begin
          if (w_drain) w_main_sel = MAIN_LOAD_SKID;
        end
        default: begin
          w_main_sel  = MAIN_HOLD;
          w_skid_load = 1'b0;
        end
      endcase
    end
  end

  // Payload registers. They keep stale contents after a flush, which is
  // harmless because out_valid is low then.
  // NOTE: these are two plain registers rather than a memory array, so they
  // are reset to give a defined out_data right after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      unique case (w_main_sel)
        MAIN_LOAD_IN:   r_main_data <= bus.in_data;
        MAIN_LOAD_SKID: r_main_data <= r_skid_data;
        default:        r_main_data <= r_main_data;
      endcase
      if (w_skid_load) r_skid_data <= bus.in_data;
    end
  end

  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = r_main_data;
  assign bus.in_ready  = ~w_skid_valid;
  assign bus.occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

  // Structural invariants of the stage.
  a_no_illegal_state: assert property (
    @(posedge clock) disable iff (!reset_n) r_state != 2'b10);

  a_occupancy_max: assert property (
    @(posedge clock) disable iff (!reset_n) bus.occupancy <= 2'd2);

  a_stall_stable: assert property (
    @(posedge clock) disable iff (!reset_n)
    (bus.out_valid && !bus.out_ready && !bus.flush)
      |=> (bus.out_valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg.
// A queue model (capacity two) predicts every output on each falling edge.
// Directed literal checks pin the model to the stage's defined behaviour.
module tb_pipe_skid_reg;

  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset_n;

  pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

  pipe_skid_reg #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Entries in acceptance order; front is presented downstream.
  logic [WIDTH-1:0] m_q[$];
  int               n_acc   = 0;
  bit               m_stall = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    bit acc, drn;
    if (!reset_n) begin
      m_q.delete();
      m_stall = 1'b0;
    end else if (bus.flush) begin
      m_q.delete();
      m_stall = 1'b0;
    end else begin
      acc     = bus.in_valid && (m_q.size() < 2);
      drn     = (m_q.size() > 0) && bus.out_ready;
      m_stall = (m_q.size() > 0) && !bus.out_ready;
      if (drn) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(bus.in_data);
        n_acc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [WIDTH-1:0] prev_out_data = '0;

  always @(negedge clock) begin
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_q.size() > 0});
    check("in_ready",  {31'b0, bus.in_ready},  {31'b0, m_q.size() < 2});
    check("occupancy", {30'b0, bus.occupancy}, m_q.size());
    if (m_q.size() > 0) check("out_data", bus.out_data, m_q[0]);
    if (m_stall) check("stall_stable", bus.out_data, prev_out_data);
    prev_out_data = bus.out_data;
  end

  // ---------------- stimulus ----------------
  // Drive inputs just after a falling edge, then wait one full cycle.
  task automatic cyc(input logic iv, input logic [WIDTH-1:0] id,
                     input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(negedge clock);
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [WIDTH-1:0] od,
                            input logic ir, input logic [1:0] occ);
    check({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, ov});
    if (ov) check({tag, ".out_data"}, bus.out_data, od);
    check({tag, ".in_ready"},  {31'b0, bus.in_ready}, {31'b0, ir});
    check({tag, ".occupancy"}, {30'b0, bus.occupancy}, {30'b0, occ});
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5;
    bus.out_ready = 1'b0;

    // 1. Reset: outputs idle for two cycles while an offer is present.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst.out_data", bus.out_data, 32'h0);
      expect_out("rst", 1'b0, '0, 1'b1, 2'd0);
    end
    reset_n = 1'b1;
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    expect_out("first_acc", 1'b1, 32'h5, 1'b1, 2'd1);

    // 2. Streaming: 5 drains as 1 enters, then 2 and 3 back-to-back.
    cyc(1'b1, 32'h1, 1'b1, 1'b0);
    expect_out("stream1", 1'b1, 32'h1, 1'b1, 2'd1);
    cyc(1'b1, 32'h2, 1'b1, 1'b0);
    expect_out("stream2", 1'b1, 32'h2, 1'b1, 2'd1);
    cyc(1'b1, 32'h3, 1'b1, 1'b0);
    expect_out("stream3", 1'b1, 32'h3, 1'b1, 2'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("stream_end", 1'b0, '0, 1'b1, 2'd0);

    // 3. Stall and skid, then drain both.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    expect_out("skid1", 1'b1, 32'hA, 1'b1, 2'd1);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    expect_out("skid2", 1'b1, 32'hA, 1'b0, 2'd2);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    expect_out("skid_hold", 1'b1, 32'hA, 1'b0, 2'd2);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("unskid1", 1'b1, 32'hB, 1'b1, 2'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("unskid2", 1'b0, '0, 1'b1, 2'd0);

    // 4. Flush while FULL drops both entries and the concurrent offer.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    expect_out("pre_flush", 1'b1, 32'hA, 1'b0, 2'd2);
    cyc(1'b1, 32'hC, 1'b1, 1'b1);
    expect_out("flush", 1'b0, '0, 1'b1, 2'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("post_flush", 1'b0, '0, 1'b1, 2'd0);

    // 5. Asynchronous reset between edges while FULL.
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    expect_out("pre_arst", 1'b1, 32'hA, 1'b0, 2'd2);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 expect_out("arst", 1'b0, '0, 1'b1, 2'd0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("post_arst", 1'b0, '0, 1'b1, 2'd0);

    // 6. Random handshake with an incrementing payload.
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), 32'h100 + n_acc, 1'($urandom_range(0, 1)), 1'b0);
      if (bus.occupancy > 2'd2) check("occ_bound", {30'b0, bus.occupancy}, 32'd2);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    expect_out("rand_drained", 1'b0, '0, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It is inserted between two processor pipeline stages, for example fetch to decode, in place of a bare D flip-flop stage. Downstream stalls are absorbed without a combinational ready path from the consumer back to the producer. A synchronous flush discards in-flight data on a branch redirect.

Parameters:
WIDTH, 32, payload width in bits.

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all stored entries.
in_valid  input  1  upstream offers in_data.
in_data  input  WIDTH  upstream payload.
in_ready  output  1  stage can accept this cycle; driven directly from a flop.
out_valid  output  1  out_data holds a valid entry.
out_data  output  WIDTH  payload presented downstream.
out_ready  input  1  downstream consumes this cycle.
occupancy  output  2  number of stored entries, 0 to 2.

Behaviour:
- Event definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - Both are evaluated on the rising edge of clock.
- Storage: main register (main_valid, main_data) and skid register (skid_valid, skid_data).
- Output mapping:
  - out_valid = main_valid; out_data = main_data.
  - in_ready = ~skid_valid.
  - occupancy = main_valid + skid_valid.
- Reset (reset_n low, asynchronous, takes effect immediately):
  - main_valid = 0, skid_valid = 0, main_data = 0, skid_data = 0.
  - Hence out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0.
  - Reset asserted mid-transfer discards both entries.
  - The first accept is possible on the first rising edge after reset_n is released.
- States, decoded from (main_valid, skid_valid):
  - EMPTY = (0,0), ONE = (1,0), FULL = (1,1).
  - (0,1) is illegal and never reached.
- EMPTY:
  - accept -> ONE, main_data <= in_data.
  - otherwise stay in EMPTY.
  - out_ready is ignored because out_valid = 0.
- ONE:
  - accept & drain -> ONE, main_data <= in_data (back-to-back streaming).
  - accept & ~drain -> FULL, skid_data <= in_data, main_data held.
  - ~accept & drain -> EMPTY.
  - neither -> hold.
- FULL:
  - in_ready = 0, so no accept is possible.
  - drain -> ONE, main_data <= skid_data, skid cleared.
  - ~drain -> hold.
- Latency: an entry accepted at edge N appears on out_valid/out_data after edge N (one cycle) when the stage was EMPTY, or when it was ONE and drained on the same edge.
- Throughput: one transfer per cycle while out_ready stays high.
- Stability: while out_valid = 1 and out_ready = 0, out_data must not change.
- Ordering: entries leave strictly in acceptance order. No duplication, no loss except on flush or reset.
- flush (takes priority over all other events at that edge):
  - main_valid <= 0, skid_valid <= 0.
  - Any accept or drain in the same cycle is ignored; the offered input is dropped.
  - The next state is EMPTY with in_ready = 1.
  - Data registers may keep stale contents while out_valid = 0.
- in_valid and in_data are only sampled when in_ready = 1. The upstream holds its offer while in_ready = 0; the stage does not check this.
- Width rule: occupancy is 2 bits and never exceeds 2.

Test Plan:
1. Reset:
   - Stimulus: reset_n = 0 for 2 cycles, in_valid = 1, in_data = 0x5.
   - Required: out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0 throughout. After release, the first edge with in_valid = 1 accepts.
2. Streaming:
   - Stimulus: out_ready = 1; in_data = 0x1, 0x2, 0x3 on consecutive cycles with in_valid = 1.
   - Required: out_data = 0x1, 0x2, 0x3 one cycle later each; out_valid continuous; in_ready stays 1; occupancy = 1.
3. Stall and skid:
   - Stimulus: out_ready = 0; accept 0xA, then 0xB.
   - Required: occupancy goes 1 then 2; in_ready = 0 after the second edge; out_data stays 0xA.
   - Then raise out_ready for 2 cycles: out_data is 0xA then 0xB, in_ready returns to 1, occupancy ends at 0.
4. Flush while FULL:
   - Stimulus: hold 0xA and 0xB (FULL); assert flush together with out_ready = 1 and in_valid = 1, in_data = 0xC.
   - Required: next cycle out_valid = 0, occupancy = 0, in_ready = 1. 0xC is never output.
5. Asynchronous reset mid-stall:
   - Stimulus: in state FULL, pull reset_n low between clock edges.
   - Required: out_valid falls before the next rising edge; in_ready = 1; no stale entry is output after release.
6. Random ordering:
   - Stimulus: 200 cycles of random in_valid/out_ready with an incrementing in_data.
   - Required: the output sequence is strictly incrementing with no gaps or duplicates; occupancy ≤ 2; out_data is stable during stalls.
